// File: rtl/ac_store_ctrl_if.sv
// Memory-side bus of the AC store/verify controller.
//   mem_addr  : word address of the current request
//   mem_wdata : data to be written (WR phase)
//   mem_we    : write request
//   mem_re    : read request
//   mem_ack   : memory acknowledge for the current request
//   mem_rdata : read data, valid with mem_ack during a read
// The master modport is the controller; the slave modport is the memory.
interface ac_store_ctrl_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 12
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_re,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_re,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/ac_store_ctrl.sv
// Store/verify controller for the accumulator read side.
// On st_start it snapshots acout and st_addr, writes the word to memory,
// reads it back and compares, then pulses st_done with a 2-bit status.
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   st_start       : store command, sampled only when idle
//   st_addr, acout : target address and AC value, sampled with st_start
//   st_busy        : write or read phase in progress
//   st_done        : one-cycle completion pulse
//   st_status      : 00 ok, 01 mismatch, 10 write timeout, 11 read timeout
//   mem            : memory request/acknowledge bus (master side)
module ac_store_ctrl #(
  parameter int unsigned DW  = 16,
  parameter int unsigned AW  = 12,
  parameter int unsigned TMO = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_start,
  input  logic [AW-1:0]         st_addr,
  input  logic [DW-1:0]         acout,
  output logic                  st_busy,
  output logic                  st_done,
  output logic [1:0]            st_status,
  ac_store_ctrl_if.master       mem
);

  localparam int unsigned     CW      = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0]   CntLast = CW'(TMO - 1);

  localparam logic [1:0] StatOk     = 2'b00;
  localparam logic [1:0] StatMis    = 2'b01;
  localparam logic [1:0] StatWrTmo  = 2'b10;
  localparam logic [1:0] StatRdTmo  = 2'b11;

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] snap_q, snap_d;
  logic          done_q, done_d;
  logic [1:0]    status_q, status_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      snap_q   <= '0;
      done_q   <= 1'b0;
      status_q <= StatOk;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      snap_q   <= snap_d;
      done_q   <= done_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    snap_d   = snap_q;
    done_d   = 1'b0;
    status_d = status_q;
    unique case (state_q)
      StIdle: begin
        if (st_start) begin
          snap_d  = acout;
          addr_d  = st_addr;
          cnt_d   = '0;
          state_d = StWr;
        end
      end
      StWr: begin
        // Ack is checked first so it wins over a same-cycle timeout.
        if (mem.mem_ack) begin
          state_d = StRd;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d  = StIdle;
          done_d   = 1'b1;
          status_d = StatWrTmo;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRd: begin
        if (mem.mem_ack) begin
          state_d  = StIdle;
          done_d   = 1'b1;
          status_d = (mem.mem_rdata == snap_q) ? StatOk : StatMis;
        end else if (cnt_q == CntLast) begin
          state_d  = StIdle;
          done_d   = 1'b1;
          status_d = StatRdTmo;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Address and write data come straight from the frozen snapshot registers.
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = snap_q;
  assign mem.mem_we    = (state_q == StWr);
  assign mem.mem_re    = (state_q == StRd);
  assign st_busy       = (state_q != StIdle);
  assign st_done       = done_q;
  assign st_status     = status_q;

endmodule

// File: tb/tb_ac_store_ctrl.sv
module tb_ac_store_ctrl;
  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 12;
  localparam int unsigned TMO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_start;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] acout;
  logic          st_busy;
  logic          st_done;
  logic [1:0]    st_status;

  ac_store_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  ac_store_ctrl #(.DW(DW), .AW(AW), .TMO(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .st_start (st_start),
    .st_addr  (st_addr),
    .acout    (acout),
    .st_busy  (st_busy),
    .st_done  (st_done),
    .st_status(st_status),
    .mem      (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Transaction-level model: phase 0 idle, 1 write, 2 read; elapsed counts
  // cycles already spent in the current phase.
  int            m_phase   = 0;
  int            m_elapsed = 0;
  logic [AW-1:0] m_addr    = '0;
  logic [DW-1:0] m_snap    = '0;
  bit            m_done    = 0;
  int            m_status  = 0;
  bit            cmp_en    = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_elapsed = 0; m_addr = '0; m_snap = '0; m_done = 0; m_status = 0;
    end else begin
      m_done = 0;
      if (m_phase == 0) begin
        if (st_start) begin
          m_phase = 1; m_elapsed = 1; m_addr = st_addr; m_snap = acout;
        end
      end else if (bus.mem_ack) begin
        if (m_phase == 1) begin
          m_phase = 2; m_elapsed = 1;
        end else begin
          m_phase = 0; m_done = 1; m_status = (bus.mem_rdata == m_snap) ? 0 : 1;
        end
      end else if (m_elapsed == TMO) begin
        m_done = 1; m_status = (m_phase == 1) ? 2 : 3; m_phase = 0;
      end else begin
        m_elapsed++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("busy", 32'(st_busy), 32'(m_phase != 0));
      chk("we",   32'(bus.mem_we), 32'(m_phase == 1));
      chk("re",   32'(bus.mem_re), 32'(m_phase == 2));
      chk("done", 32'(st_done), 32'(m_done));
      if (m_done) chk("status", 32'(st_status), 32'(m_status));
      if (m_phase != 0) chk("addr", 32'(bus.mem_addr), 32'(m_addr));
      if (m_phase == 1) chk("wdata", 32'(bus.mem_wdata), 32'(m_snap));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    st_start = 0; bus.mem_ack = 0; bus.mem_rdata = '0;
  endtask

  // Drive st_start for one cycle (cycle 0); returns at the start of cycle 1.
  task automatic start_txn(input logic [AW-1:0] a, input logic [DW-1:0] d);
    st_start = 1; st_addr = a; acout = d;
    step();
    st_start = 0;
  endtask

  initial begin
    int  cnt;
    bit  seen;
    rst = 1; st_start = 0; st_addr = '0; acout = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    step();
    cmp_en = 1;
    @(negedge clk);
    chk("rst_busy", 32'(st_busy), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_re", 32'(bus.mem_re), 0);
    chk("rst_done", 32'(st_done), 0);
    chk("rst_status", 32'(st_status), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_wdata", 32'(bus.mem_wdata), 0);
    step();
    rst = 0;
    step();

    // Basic store
    start_txn(12'h1F0, 16'hA5C3);
    bus.mem_ack = 1;
    @(negedge clk);
    chk("basic_c1_we", 32'(bus.mem_we), 1);
    chk("basic_c1_re", 32'(bus.mem_re), 0);
    step();
    bus.mem_ack = 1; bus.mem_rdata = 16'hA5C3;
    @(negedge clk);
    chk("basic_c2_we", 32'(bus.mem_we), 0);
    chk("basic_c2_re", 32'(bus.mem_re), 1);
    step();
    idle_inputs();
    @(negedge clk);
    chk("basic_c3_done", 32'(st_done), 1);
    chk("basic_c3_status", 32'(st_status), 0);
    chk("basic_c3_busy", 32'(st_busy), 0);
    step();

    // Mismatch with AC change after snapshot
    start_txn(12'h1F0, 16'hA5C3);
    acout = 16'hFFFF; bus.mem_ack = 1;
    @(negedge clk);
    chk("mis_wdata", 32'(bus.mem_wdata), 32'h0000A5C3);
    step();
    bus.mem_ack = 1; bus.mem_rdata = 16'hA5C2;
    step();
    idle_inputs();
    @(negedge clk);
    chk("mis_done", 32'(st_done), 1);
    chk("mis_status", 32'(st_status), 1);
    step();

    // Write timeout
    start_txn(12'h005, 16'h0001);
    cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_we) cnt++;
      if (st_done) begin
        seen = 1;
        chk("wto_cycle", 32'(i + 1), 16);
        chk("wto_status", 32'(st_status), 2);
      end
      step();
    end
    chk("wto_seen", 32'(seen), 1);
    chk("wto_we_cycles", 32'(cnt), 15);

    // Read timeout
    start_txn(12'h006, 16'h0002);
    bus.mem_ack = 1;
    step();
    bus.mem_ack = 0;
    cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_re) cnt++;
      if (st_done) begin
        seen = 1;
        chk("rto_cycle", 32'(i + 2), 17);
        chk("rto_status", 32'(st_status), 3);
      end
      step();
    end
    chk("rto_seen", 32'(seen), 1);
    chk("rto_re_cycles", 32'(cnt), 15);

    // Ack on last write cycle
    start_txn(12'h007, 16'h1234);
    repeat (14) step();
    bus.mem_ack = 1;
    @(negedge clk);
    chk("last_c15_we", 32'(bus.mem_we), 1);
    step();
    bus.mem_ack = 1; bus.mem_rdata = 16'h1234;
    @(negedge clk);
    chk("last_c16_re", 32'(bus.mem_re), 1);
    chk("last_c16_done", 32'(st_done), 0);
    step();
    idle_inputs();
    @(negedge clk);
    chk("last_done", 32'(st_done), 1);
    chk("last_status", 32'(st_status), 0);
    step();

    // Ignored start while busy, ignored ack while idle
    start_txn(12'h0AA, 16'h5555);
    st_start = 1; st_addr = 12'h0BB; acout = 16'h6666; bus.mem_ack = 1;
    step();
    st_start = 0; bus.mem_ack = 1; bus.mem_rdata = 16'h5555;
    @(negedge clk);
    chk("ign_addr", 32'(bus.mem_addr), 32'h0AA);
    step();
    idle_inputs();
    @(negedge clk);
    chk("ign_status", 32'(st_status), 0);
    step();
    bus.mem_ack = 1;
    @(negedge clk);
    chk("ign_busy", 32'(st_busy), 0);
    step();
    bus.mem_ack = 0;
    @(negedge clk);
    chk("ign_busy2", 32'(st_busy), 0);
    chk("ign_we", 32'(bus.mem_we), 0);
    step();

    // Reset during read phase
    start_txn(12'h321, 16'hBEEF);
    bus.mem_ack = 1;
    step();
    bus.mem_ack = 0; rst = 1;
    @(negedge clk);
    chk("rrd_re_before", 32'(bus.mem_re), 1);
    step();
    rst = 0;
    @(negedge clk);
    chk("rrd_busy", 32'(st_busy), 0);
    chk("rrd_re", 32'(bus.mem_re), 0);
    chk("rrd_done", 32'(st_done), 0);
    chk("rrd_addr", 32'(bus.mem_addr), 0);
    chk("rrd_wdata", 32'(bus.mem_wdata), 0);
    chk("rrd_status", 32'(st_status), 0);
    step();
    @(negedge clk);
    chk("rrd_done2", 32'(st_done), 0);
    step();

    // Back-to-back
    start_txn(12'h010, 16'h0F0F);
    bus.mem_ack = 1;
    step();
    bus.mem_ack = 1; bus.mem_rdata = 16'h0F0F;
    step();
    bus.mem_ack = 0; st_start = 1; st_addr = 12'h020; acout = 16'h1111;
    @(negedge clk);
    chk("b2b_done", 32'(st_done), 1);
    step();
    st_start = 0;
    @(negedge clk);
    chk("b2b_we", 32'(bus.mem_we), 1);
    chk("b2b_addr", 32'(bus.mem_addr), 32'h020);
    bus.mem_ack = 1; bus.mem_rdata = 16'h1111;
    repeat (3) step();
    idle_inputs();
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      st_start      = ($urandom_range(0, 9) < 3);
      st_addr       = AW'($urandom);
      acout         = DW'($urandom);
      bus.mem_ack   = ($urandom_range(0, 15) < 3);
      bus.mem_rdata = $urandom_range(0, 1) ? m_snap : DW'($urandom);
      step();
    end
    rst = 0;
    idle_inputs();
    repeat (2 * TMO + 4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ac_store_ctrl.md
# ac_store_ctrl

Store/verify controller on the read side of the 16-bit accumulator (AC). On a store command it snapshots the AC output and the target address, writes the word to memory over a request/acknowledge handshake, reads it back, and compares. It finishes with a one-cycle done pulse and a 2-bit status. It sits between the control sequencer (STA-type instructions), the AC register outputs and the memory port.

## Interface
- DW, 16, data width; equals the AC width.
- AW, 12, memory address width.
- TMO, 15, maximum cycles per handshake phase before timeout; legal range 2..255.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- st_start  in  1  store command; sampled only in IDLE.
- st_addr  in  AW  target address; sampled with st_start.
- acout  in  DW  accumulator output; sampled with st_start.
- st_busy  out  1  transaction in progress (WR or RD state).
- st_done  out  1  one-cycle completion pulse.
- st_status  out  2  outcome, valid only while st_done=1:
  - 00 ok
  - 01 read-back mismatch
  - 10 write timeout
  - 11 read timeout
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  write data.
- mem_we  out  1  write request.
- mem_re  out  1  read request.
- mem_ack  in  1  memory acknowledge for the current request.
- mem_rdata  in  DW  read data; valid in the cycle where mem_ack=1 during RD.

## Operation
- States: IDLE, WR, RD.
- IDLE:
  - If st_start=1 at a rising edge: latch acout into a snapshot register and st_addr into an address register, clear the phase counter, go to WR.
  - Otherwise stay in IDLE.
  - mem_ack is ignored in IDLE.
- WR:
  - mem_we=1, mem_addr=latched address, mem_wdata=snapshot.
  - mem_ack=1 at an edge: go to RD and clear the counter.
  - Else, if counter = TMO-1: go to IDLE, st_done=1, st_status=10.
  - Else: increment the counter.
- RD:
  - mem_re=1, mem_addr=latched address.
  - mem_ack=1 at an edge: compare mem_rdata with the snapshot, go to IDLE, st_done=1, st_status=00 if equal, 01 if not.
  - Else, if counter = TMO-1: go to IDLE, st_done=1, st_status=11.
  - Else: increment the counter.
- Ack versus timeout in the same cycle: the ack wins and the phase completes normally.
- mem_we and mem_re are never high together.
- st_start while st_busy=1 is ignored; it is not queued.
- The snapshot is frozen for the whole transaction. Later changes on acout, including an AC load or clear, do not affect mem_wdata or the comparison.
- The counter width is ceil(log2(TMO)) bits. It never wraps, because the timeout fires at TMO-1.
- st_done and st_status are registered outputs. st_status holds its last value between pulses, but it is only meaningful while st_done=1.

## Timing
- Reset (rst=1 at an edge) forces:
  - state=IDLE
  - st_busy=0, st_done=0, st_status=00
  - mem_we=0, mem_re=0
  - mem_addr=0, mem_wdata=0
  - counter=0
- Reset mid-transaction aborts it with no done pulse. Reset has priority over st_start.
- Cycle numbering: st_start is sampled at the edge ending cycle 0.
  - Cycle 1: mem_we=1 and st_busy=1.
  - Ack during cycle k ends WR; mem_re=1 from cycle k+1.
  - Ack during RD cycle m: st_done=1 and st_busy=0 in cycle m+1.
- Minimum latency: st_start to st_done is 3 cycles (ack in cycles 1 and 2).
- Maximum latency: 2*TMO+1 cycles.
- Write timeout: mem_we is high for exactly TMO cycles, then st_done pulses in the next cycle.
- Read timeout: mem_re is high for exactly TMO cycles, then st_done pulses in the next cycle.
- Back-to-back: a new st_start is accepted in the st_done cycle, so mem_we can rise in the cycle after st_done.

## Test plan
- Basic store: acout=16'hA5C3, st_addr=12'h1F0, mem_ack in cycles 1 and 2, mem_rdata=16'hA5C3. Expect mem_we high in cycle 1 only, mem_re high in cycle 2 only, st_done=1 with status 00 in cycle 3.
- Mismatch plus AC change: same as basic store but acout changes to 16'hFFFF in cycle 1 and mem_rdata=16'hA5C2. Expect mem_wdata=16'hA5C3 throughout and status 01.
- Timeouts with TMO=15: mem_ack never asserted gives mem_we high in cycles 1..15 and status 10 in cycle 16. A separate run with ack only in WR gives status 11 after 15 mem_re cycles.
- Ack on the last phase cycle: mem_ack in cycle 15 of WR. Expect a transition to RD with no timeout.
- Ignored inputs: st_start pulsed while busy, and mem_ack pulsed in IDLE. Expect no second transaction and no state change.
- Reset and back-to-back: rst asserted during RD. Expect all outputs at reset values next cycle and no st_done. Then st_start in the st_done cycle of a clean transaction; expect mem_we=1 in the following cycle.
